// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit pipeline: opcodes, flag bit positions and
// the EX/MEM boundary record.
package pipe_pkg;
    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef struct packed {
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     store_data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memtoreg;
        logic                  memwrite;
        logic                  halt;
    } exmem_t;

    localparam exmem_t EXMEM_BUBBLE = '0;

    function automatic logic writes_z(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRA, OP_ROR};
    endfunction

    function automatic logic writes_vn(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB};
    endfunction
endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, MEM/WB forwarding source and EX/MEM outputs of the execute stage.
interface ex_stage_if;
    import pipe_pkg::*;

    logic                  wen;
    logic                  flush;
    logic [DATA_W-1:0]     ide_pc;
    logic [DATA_W-1:0]     ide_data1;
    logic [DATA_W-1:0]     ide_data2;
    logic [DATA_W-1:0]     ide_instr;
    logic                  ide_regwrite;
    logic [REG_ADDR_W-1:0] ide_reg_write_select;
    logic                  ide_memtoreg;
    logic                  ide_memwrite;
    logic                  memwb_regwrite;
    logic [REG_ADDR_W-1:0] memwb_reg_write_select;
    logic [DATA_W-1:0]     memwb_data;
    logic [DATA_W-1:0]     exm_alu_result;
    logic [DATA_W-1:0]     exm_store_data;
    logic [REG_ADDR_W-1:0] exm_reg_write_select;
    logic                  exm_regwrite;
    logic                  exm_memtoreg;
    logic                  exm_memwrite;
    logic                  exm_halt;
    logic [2:0]            flags;

    modport master (
        output wen, flush, ide_pc, ide_data1, ide_data2, ide_instr, ide_regwrite,
               ide_reg_write_select, ide_memtoreg, ide_memwrite,
               memwb_regwrite, memwb_reg_write_select, memwb_data,
        input  exm_alu_result, exm_store_data, exm_reg_write_select, exm_regwrite,
               exm_memtoreg, exm_memwrite, exm_halt, flags
    );

    modport slave (
        input  wen, flush, ide_pc, ide_data1, ide_data2, ide_instr, ide_regwrite,
               ide_reg_write_select, ide_memtoreg, ide_memwrite,
               memwb_regwrite, memwb_reg_write_select, memwb_data,
        output exm_alu_result, exm_store_data, exm_reg_write_select, exm_regwrite,
               exm_memtoreg, exm_memwrite, exm_halt, flags
    );
endinterface

// File: rtl/alu16.sv
// Combinational 16-bit ALU: saturating add/sub, logic, shifts, nibble SIMD add
// and load/store address generation.
module alu16 import pipe_pkg::*; (
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [7:0]        i_imm,
    output logic [DATA_W-1:0] o_result,
    output logic              o_z,
    output logic              o_v,
    output logic              o_n
);
    genvar gi;

    logic [16:0] w_sum;
    logic [16:0] w_diff;
    logic        w_sum_ovf;
    logic        w_diff_ovf;
    logic [15:0] w_sum_sat;
    logic [15:0] w_diff_sat;
    logic [15:0] w_red;
    logic [15:0] w_sll;
    logic [15:0] w_sra;
    logic [15:0] w_ror;
    logic [15:0] w_paddsb;
    logic [15:0] w_addr;

    // One guard bit: overflow shows up as disagreement between bits 16 and 15.
    assign w_sum      = {i_a[15], i_a} + {i_b[15], i_b};
    assign w_diff     = {i_a[15], i_a} - {i_b[15], i_b};
    assign w_sum_ovf  = w_sum[16] ^ w_sum[15];
    assign w_diff_ovf = w_diff[16] ^ w_diff[15];
    assign w_sum_sat  = w_sum_ovf  ? (w_sum[16]  ? 16'h8000 : 16'h7FFF) : w_sum[15:0];
    assign w_diff_sat = w_diff_ovf ? (w_diff[16] ? 16'h8000 : 16'h7FFF) : w_diff[15:0];

    assign w_red = {{8{i_a[15]}}, i_a[15:8]} + {{8{i_a[7]}}, i_a[7:0]}
                 + {{8{i_b[15]}}, i_b[15:8]} + {{8{i_b[7]}}, i_b[7:0]};

    assign w_sll = i_a << i_imm[3:0];
    assign w_sra = $unsigned($signed(i_a) >>> i_imm[3:0]);
    assign w_ror = (i_a >> i_imm[3:0]) | (i_a << (5'd16 - {1'b0, i_imm[3:0]}));

    for (gi = 0; gi < 4; gi++) begin : g_nib
        logic [4:0] w_nsum;
        assign w_nsum = {i_a[4*gi+3], i_a[4*gi +: 4]} + {i_b[4*gi+3], i_b[4*gi +: 4]};
        assign w_paddsb[4*gi +: 4] = (w_nsum[4] ^ w_nsum[3]) ? (w_nsum[4] ? 4'h8 : 4'h7)
                                                              : w_nsum[3:0];
    end

    // Word-aligned base plus signed word offset.
    assign w_addr = (i_a & 16'hFFFE) + {{11{i_imm[3]}}, i_imm[3:0], 1'b0};

    always_comb begin
        o_result = '0;
        o_v      = 1'b0;
        case (i_op)
            OP_ADD:       begin o_result = w_sum_sat;  o_v = w_sum_ovf;  end
            OP_SUB:       begin o_result = w_diff_sat; o_v = w_diff_ovf; end
            OP_XOR:       o_result = i_a ^ i_b;
            OP_RED:       o_result = w_red;
            OP_SLL:       o_result = w_sll;
            OP_SRA:       o_result = w_sra;
            OP_ROR:       o_result = w_ror;
            OP_PADDSB:    o_result = w_paddsb;
            OP_LW, OP_SW: o_result = w_addr;
            OP_LLB:       o_result = {i_a[15:8], i_imm};
            OP_LHB:       o_result = {i_imm, i_a[7:0]};
            default:      o_result = '0;
        endcase
    end

    assign o_z = (o_result == '0);
    assign o_n = o_result[15];
endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, EX/MEM pipeline register and the
// architectural Z/V/N flag register.
module ex_stage import pipe_pkg::*; (
    input logic       clk,
    input logic       rst,
    ex_stage_if.slave bus
);
    genvar gi;

    exmem_t            r_exm;
    logic [2:0]        r_flags;
    exmem_t            w_exm_next;
    logic [3:0]        w_op;
    logic [3:0]        w_src [3];
    logic [DATA_W-1:0] w_rf  [3];
    logic [DATA_W-1:0] w_fwd [3];
    logic [DATA_W-1:0] w_alu_result;
    logic              w_z;
    logic              w_v;
    logic              w_n;

    assign w_op = bus.ide_instr[15:12];

    // Operand slots: ALU A, ALU B, store data. LLB/LHB read-modify their destination.
    assign w_src[0] = (w_op == OP_LLB || w_op == OP_LHB) ? bus.ide_instr[11:8] : bus.ide_instr[7:4];
    assign w_src[1] = bus.ide_instr[3:0];
    assign w_src[2] = bus.ide_instr[11:8];
    assign w_rf[0]  = bus.ide_data1;
    assign w_rf[1]  = bus.ide_data2;
    assign w_rf[2]  = bus.ide_data2;

    // Loads in EX/MEM are excluded; the hazard unit inserts the load-use stall.
    for (gi = 0; gi < 3; gi++) begin : g_fwd
        logic w_hit_exm;
        logic w_hit_wb;
        assign w_hit_exm = (w_src[gi] != '0) && r_exm.regwrite && !r_exm.memtoreg
                         && (r_exm.rd == w_src[gi]);
        assign w_hit_wb  = (w_src[gi] != '0) && bus.memwb_regwrite
                         && (bus.memwb_reg_write_select == w_src[gi]);
        assign w_fwd[gi] = w_hit_exm ? r_exm.alu_result :
                           w_hit_wb  ? bus.memwb_data   : w_rf[gi];
    end

    alu16 u_alu (
        .i_op     (w_op),
        .i_a      (w_fwd[0]),
        .i_b      (w_fwd[1]),
        .i_imm    (bus.ide_instr[7:0]),
        .o_result (w_alu_result),
        .o_z      (w_z),
        .o_v      (w_v),
        .o_n      (w_n)
    );

    always_comb begin
        w_exm_next            = EXMEM_BUBBLE;
        w_exm_next.alu_result = (w_op == OP_PCS) ? bus.ide_pc : w_alu_result;
        w_exm_next.store_data = w_fwd[2];
        w_exm_next.rd         = bus.ide_reg_write_select;
        w_exm_next.regwrite   = bus.ide_regwrite;
        w_exm_next.memtoreg   = bus.ide_memtoreg;
        w_exm_next.memwrite   = bus.ide_memwrite;
        w_exm_next.halt       = (w_op == OP_HLT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_exm   <= EXMEM_BUBBLE;
            r_flags <= '0;
        end else if (bus.flush) begin
            r_exm <= EXMEM_BUBBLE;
        end else if (bus.wen) begin
            r_exm <= w_exm_next;
            if (writes_z(w_op)) begin
                r_flags[FLAG_Z] <= w_z;
            end
            if (writes_vn(w_op)) begin
                r_flags[FLAG_V] <= w_v;
                r_flags[FLAG_N] <= w_n;
            end
        end
    end

    assign bus.exm_alu_result       = r_exm.alu_result;
    assign bus.exm_store_data       = r_exm.store_data;
    assign bus.exm_reg_write_select = r_exm.rd;
    assign bus.exm_regwrite         = r_exm.regwrite;
    assign bus.exm_memtoreg         = r_exm.memtoreg;
    assign bus.exm_memwrite         = r_exm.memwrite;
    assign bus.exm_halt             = r_exm.halt;
    assign bus.flags                = r_flags;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios plus randomized traffic against an
// integer-arithmetic reference model of the execute stage.
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ex_stage_if bus();

    ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model of the EX/MEM view and flags.
    logic [15:0] m_res, m_store;
    logic [3:0]  m_rd;
    logic        m_rw, m_mtr, m_mw, m_halt;
    logic [2:0]  m_flags;
    logic        m_res_chk, m_st_chk;

    function automatic int sx8(input logic [7:0] x);
        return int'($signed(x));
    endfunction

    function automatic int sx4(input logic [3:0] x);
        return int'($signed(x));
    endfunction

    function automatic logic [15:0] ref_alu(input logic [15:0] instr, input logic [15:0] a,
                                            input logic [15:0] b, input logic [15:0] pc,
                                            output logic sat);
        int s;
        int sa;
        int sb;
        int amt;
        logic [15:0] r;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        amt = int'(instr[3:0]);
        sat = 1'b0;
        r   = 16'h0000;
        case (instr[15:12])
            4'h0, 4'h1: begin
                s = (instr[15:12] == 4'h0) ? sa + sb : sa - sb;
                if (s > 32767) begin r = 16'h7FFF; sat = 1'b1; end
                else if (s < -32768) begin r = 16'h8000; sat = 1'b1; end
                else r = s[15:0];
            end
            4'h2: r = a ^ b;
            4'h3: begin s = sx8(a[15:8]) + sx8(a[7:0]) + sx8(b[15:8]) + sx8(b[7:0]); r = s[15:0]; end
            4'h4: r = a << amt;
            4'h5: begin s = sa >>> amt; r = s[15:0]; end
            4'h6: begin r = a; repeat (amt) r = {r[0], r[15:1]}; end
            4'h7: begin
                for (int i = 0; i < 4; i++) begin
                    s = sx4(a[4*i +: 4]) + sx4(b[4*i +: 4]);
                    if (s > 7) s = 7;
                    if (s < -8) s = -8;
                    r[4*i +: 4] = s[3:0];
                end
            end
            4'h8, 4'h9: begin s = int'(a & 16'hFFFE) + 2 * sx4(instr[3:0]); r = s[15:0]; end
            4'hA: r = (a & 16'hFF00) | {8'h00, instr[7:0]};
            4'hB: r = (a & 16'h00FF) | {instr[7:0], 8'h00};
            4'hE: r = pc;
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] fwd(input logic [3:0] src, input logic [15:0] rf);
        if (src != 4'd0 && m_rw && !m_mtr && m_rd == src) return m_res;
        if (src != 4'd0 && bus.memwb_regwrite && bus.memwb_reg_write_select == src) return bus.memwb_data;
        return rf;
    endfunction

    function automatic logic [42:0] got_vec();
        return {bus.exm_alu_result, bus.exm_store_data, bus.exm_reg_write_select, bus.exm_regwrite,
                bus.exm_memtoreg, bus.exm_memwrite, bus.exm_halt, bus.flags};
    endfunction

    function automatic logic [42:0] exp_vec();
        return {m_res, m_store, m_rd, m_rw, m_mtr, m_mw, m_halt, m_flags};
    endfunction

    function automatic logic [42:0] chk_mask();
        return {{16{m_res_chk}}, {16{m_st_chk}}, 11'h7FF};
    endfunction

    // Advance one clock; the model consumes the inputs present before the edge.
    task automatic tick();
        logic [3:0]  op;
        logic [15:0] a, b, st, r;
        logic        sat;
        op = bus.ide_instr[15:12];
        a  = fwd((op == 4'hA || op == 4'hB) ? bus.ide_instr[11:8] : bus.ide_instr[7:4], bus.ide_data1);
        b  = fwd(bus.ide_instr[3:0], bus.ide_data2);
        st = fwd(bus.ide_instr[11:8], bus.ide_data2);
        r  = ref_alu(bus.ide_instr, a, b, bus.ide_pc, sat);
        @(posedge clk);
        #1;
        if (!rst) begin
            {m_res, m_store, m_rd, m_rw, m_mtr, m_mw, m_halt, m_flags} = '0;
            m_res_chk = 1'b1; m_st_chk = 1'b1;
        end else if (bus.flush) begin
            {m_res, m_store, m_rd, m_rw, m_mtr, m_mw, m_halt} = '0;
            m_res_chk = 1'b1; m_st_chk = 1'b1;
        end else if (bus.wen) begin
            if (op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6}) m_flags[2] = (r == 16'h0000);
            if (op inside {4'h0, 4'h1}) begin m_flags[1] = sat; m_flags[0] = r[15]; end
            m_res  = r;  m_store = st; m_rd = bus.ide_reg_write_select;
            m_rw   = bus.ide_regwrite; m_mtr = bus.ide_memtoreg; m_mw = bus.ide_memwrite;
            m_halt = (op == 4'hF);
            m_res_chk = !(op inside {4'hC, 4'hD, 4'hF});
            m_st_chk  = (op == 4'h9);
        end
        $display("[%0t] instr=%h rst=%b flush=%b wen=%b -> res=%h st=%h rd=%0d ctl=%b%b%b%b flags=%b",
                 $time, bus.ide_instr, rst, bus.flush, bus.wen, bus.exm_alu_result, bus.exm_store_data,
                 bus.exm_reg_write_select, bus.exm_regwrite, bus.exm_memtoreg, bus.exm_memwrite,
                 bus.exm_halt, bus.flags);
    endtask

    task automatic drive(input logic [15:0] instr, input logic [15:0] d1, input logic [15:0] d2,
                         input logic rw, input logic mw, input logic wb_rw,
                         input logic [3:0] wb_rd, input logic [15:0] wb_data);
        bus.wen = 1'b1;               bus.flush = 1'b0;
        bus.ide_instr = instr;        bus.ide_pc = 16'($urandom);
        bus.ide_data1 = d1;           bus.ide_data2 = d2;
        bus.ide_regwrite = rw;        bus.ide_reg_write_select = instr[11:8];
        bus.ide_memtoreg = 1'b0;      bus.ide_memwrite = mw;
        bus.memwb_regwrite = wb_rw;   bus.memwb_reg_write_select = wb_rd;
        bus.memwb_data = wb_data;
    endtask

    task automatic rand_inputs();
        logic [15:0] instr;
        instr = 16'($urandom);
        if ($urandom_range(0, 1) == 1) begin
            instr[11:8] = 4'($urandom_range(0, 3));
            instr[7:4]  = 4'($urandom_range(0, 3));
            instr[3:0]  = 4'($urandom_range(0, 3));
        end
        bus.ide_instr = instr;
        bus.ide_pc = 16'($urandom);
        bus.ide_data1 = 16'($urandom);
        bus.ide_data2 = 16'($urandom);
        bus.ide_regwrite = (instr[15:12] inside {4'hC, 4'hD, 4'hF}) ? 1'b0 : 1'($urandom);
        bus.ide_reg_write_select = instr[11:8];
        bus.ide_memtoreg = ($urandom_range(0, 3) == 0);
        bus.ide_memwrite = 1'($urandom);
        bus.memwb_regwrite = 1'($urandom);
        bus.memwb_reg_write_select = 4'($urandom_range(0, 3));
        bus.memwb_data = 16'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            bus.wen = 1'($urandom); bus.flush = 1'($urandom);
            tick();
            n_checks++;
            if (got_vec() !== 43'h0) begin
                n_fail++; $display("FAIL reset_state: got %h expected 0", got_vec());
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_add_sub_sat();
        drive(16'h0123, 16'h7000, 16'h2000, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
        tick();
        n_checks++;
        if (bus.exm_alu_result !== 16'h7FFF) begin n_fail++; $display("FAIL add_pos_sat: got %h expected 7fff", bus.exm_alu_result); end
        n_checks++;
        if (bus.flags !== 3'b010) begin n_fail++; $display("FAIL add_pos_sat_flags: got %b expected 010", bus.flags); end
        drive(16'h1456, 16'h0005, 16'h0005, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
        tick();
        n_checks++;
        if (bus.exm_alu_result !== 16'h0000) begin n_fail++; $display("FAIL sub_zero: got %h expected 0000", bus.exm_alu_result); end
        n_checks++;
        if (bus.flags !== 3'b100) begin n_fail++; $display("FAIL sub_zero_flags: got %b expected 100", bus.flags); end
        drive(16'h0789, 16'h8000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
        tick();
        n_checks++;
        if (bus.exm_alu_result !== 16'h8000) begin n_fail++; $display("FAIL add_neg_sat: got %h expected 8000", bus.exm_alu_result); end
        n_checks++;
        if (bus.flags !== 3'b011) begin n_fail++; $display("FAIL add_neg_sat_flags: got %b expected 011", bus.flags); end
    endtask

    task automatic test_back_to_back();
        drive(16'h0123, 16'h1234, 16'h0001, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
        tick();
        drive(16'h2211, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
        tick();
        n_checks++;
        if ({bus.exm_alu_result, bus.flags} !== {16'h0000, 3'b100}) begin
            n_fail++; $display("FAIL fwd_exmem: got %h/%b expected 0000/100", bus.exm_alu_result, bus.flags);
        end
        drive(16'h0316, 16'hDEAD, 16'h0001, 1'b1, 1'b0, 1'b1, 4'd1, 16'h1235);
        tick();
        n_checks++;
        if (bus.exm_alu_result !== 16'h1236) begin n_fail++; $display("FAIL fwd_memwb: got %h expected 1236", bus.exm_alu_result); end
        drive(16'h1437, 16'hBEEF, 16'h0006, 1'b1, 1'b0, 1'b1, 4'd3, 16'h9999);
        tick();
        n_checks++;
        if (bus.exm_alu_result !== 16'h1230) begin n_fail++; $display("FAIL fwd_priority: got %h expected 1230", bus.exm_alu_result); end
        drive(16'h0023, 16'h0100, 16'h0001, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
        tick();
        drive(16'h2500, 16'h00F0, 16'h000F, 1'b1, 1'b0, 1'b1, 4'd0, 16'hFFFF);
        tick();
        n_checks++;
        if ({bus.exm_alu_result, bus.flags} !== {16'h00FF, 3'b000}) begin
            n_fail++; $display("FAIL no_fwd_r0: got %h/%b expected 00ff/000", bus.exm_alu_result, bus.flags);
        end
    endtask

    task automatic test_stall_flush();
        logic [42:0] snap;
        drive(16'h0289, 16'h0100, 16'h0200, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
        tick();
        n_checks++;
        if (bus.exm_alu_result !== 16'h0300) begin n_fail++; $display("FAIL pre_stall: got %h expected 0300", bus.exm_alu_result); end
        snap = exp_vec();
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            bus.wen = 1'b0; bus.flush = 1'b0;
            tick();
            n_checks++;
            if (got_vec() !== snap) begin n_fail++; $display("FAIL stall_hold: got %h expected %h", got_vec(), snap); end
        end
        rand_inputs();
        bus.wen = 1'b0; bus.flush = 1'b1;
        tick();
        n_checks++;
        if (got_vec() !== {40'h0, snap[2:0]}) begin
            n_fail++; $display("FAIL flush_bubble: got %h expected %h", got_vec(), {40'h0, snap[2:0]});
        end
    endtask

    task automatic test_store();
        drive(16'h0312, 16'h4000, 16'h0BCD, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
        tick();
        drive(16'h934E, 16'h0101, 16'h1111, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0);
        tick();
        n_checks++;
        if (bus.exm_alu_result !== 16'h00FC) begin n_fail++; $display("FAIL sw_addr: got %h expected 00fc", bus.exm_alu_result); end
        n_checks++;
        if (bus.exm_store_data !== 16'h4BCD) begin n_fail++; $display("FAIL sw_data: got %h expected 4bcd", bus.exm_store_data); end
        n_checks++;
        if (bus.exm_memwrite !== 1'b1) begin n_fail++; $display("FAIL sw_memwrite: got %b expected 1", bus.exm_memwrite); end
    endtask

    task automatic test_misc_ops();
        drive(16'h7612, 16'h7777, 16'h1111, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
        tick();
        n_checks++;
        if (bus.exm_alu_result !== 16'h7777) begin n_fail++; $display("FAIL paddsb_sat: got %h expected 7777", bus.exm_alu_result); end
        drive(16'h7612, 16'h7F80, 16'h1188, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
        tick();
        n_checks++;
        if (bus.exm_alu_result !== 16'h7088) begin n_fail++; $display("FAIL paddsb_mixed: got %h expected 7088", bus.exm_alu_result); end
        drive(16'h2712, 16'h3C3C, 16'h3C3C, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
        tick();
        drive(16'hA85A, 16'h1200, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
        tick();
        n_checks++;
        if ({bus.exm_alu_result, bus.flags[2]} !== {16'h125A, 1'b1}) begin
            n_fail++; $display("FAIL llb_keeps_z: got %h/%b expected 125a/1", bus.exm_alu_result, bus.flags[2]);
        end
        drive(16'hB8C3, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
        tick();
        n_checks++;
        if (bus.exm_alu_result !== 16'hC35A) begin n_fail++; $display("FAIL lhb_fwd: got %h expected c35a", bus.exm_alu_result); end
        drive(16'hE900, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
        bus.ide_pc = 16'h0432;
        tick();
        n_checks++;
        if (bus.exm_alu_result !== 16'h0432) begin n_fail++; $display("FAIL pcs: got %h expected 0432", bus.exm_alu_result); end
        drive(16'hF000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
        tick();
        n_checks++;
        if (bus.exm_halt !== 1'b1) begin n_fail++; $display("FAIL hlt: got %b expected 1", bus.exm_halt); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            bus.wen   = ($urandom_range(0, 9) < 8);
            bus.flush = ($urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 29) != 0);
            tick();
            n_checks++;
            if ((got_vec() & chk_mask()) !== (exp_vec() & chk_mask())) begin
                n_fail++;
                $display("FAIL random_%0d: got %h expected %h", i, got_vec() & chk_mask(), exp_vec() & chk_mask());
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        drive(16'h0000, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
        {m_res, m_store, m_rd, m_rw, m_mtr, m_mw, m_halt, m_flags} = '0;
        m_res_chk = 1'b1;
        m_st_chk  = 1'b1;
        test_reset();
        test_add_sub_sat();
        test_back_to_back();
        test_stall_flush();
        test_store();
        test_misc_ops();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
